edge_noise_filter: RTL and testbench

Downstream stage of the edge detector: reads the binary edge map it writes (one word per pixel, bit 0 = edge) from shared pixel memory. Suppresses isolated edge pixels with a 3x3 neighbour-count test and writes the cleaned map to a separate destination region. Uses the same single-port memory master interface as the other vision stages (`address`/`wren`/`data_write`/`data_read`), with an `enable`/`done` handshake to the sequencer.

---
 rtl/edge_filter_pkg.sv | 30 +++
 rtl/edge_window_eval.sv | 25 ++
 rtl/edge_noise_filter.sv | 188 ++++++++++++++++++
 tb/tb_edge_noise_filter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_filter_pkg.sv
// Shared types and image geometry for the edge noise filter stage.
package edge_filter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRIME,
        READ,
        WRITE,
        BORDER,
        DONE
    } state_t;

    localparam int unsigned GEO_WIDTH     = 320;
    localparam int unsigned GEO_HEIGHT    = 240;
    localparam int unsigned GEO_FIRST_ROW = 8;
    localparam int unsigned GEO_LAST_ROW  = 231;

    // 3x3 window indexed win[r][c]; r=0 is the row above, c=0 the column to the left.
    typedef logic [2:0][2:0] win_t;

    // A full-window prime reads column by column: j=0..2 is the left column, top to bottom.
    function automatic logic [1:0] prime_dr(input logic [3:0] j);
        return 2'(j % 4'd3);
    endfunction

    function automatic logic [1:0] prime_dc(input logic [3:0] j);
        return 2'(j / 4'd3);
    endfunction

endpackage

// File: rtl/edge_window_eval.sv
// Keep/drop decision for one edge pixel from its 3x3 neighbourhood.
module edge_window_eval
    import edge_filter_pkg::*;
(
    input  win_t       win,
    input  logic [3:0] min_neighbours,
    output logic       keep
);

    logic [3:0] cnt;

    // Count the eight neighbours; a threshold above 8 can never be met.
    always_comb begin
        cnt = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 1 && c == 1)) begin
                    cnt = cnt + 4'(win[r][c]);
                end
            end
        end
        keep = win[1][1] && (cnt >= min_neighbours);
    end

endmodule

// File: rtl/edge_noise_filter.sv
// Edge noise filter: streams the edge map through a 3x3 window and writes the cleaned map.
module edge_noise_filter
    import edge_filter_pkg::*;
#(
    parameter int unsigned IMG_WIDTH = GEO_WIDTH,
    parameter int unsigned SRC_BASE  = 0,
    parameter int unsigned DST_BASE  = 153600,
    parameter int unsigned FIRST_ROW = GEO_FIRST_ROW,
    parameter int unsigned LAST_ROW  = GEO_LAST_ROW
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pause,
    input  logic        enable_edge_filter,
    input  logic [3:0]  min_neighbours,
    input  logic [31:0] data_read,
    output logic        wren,
    output logic [17:0] address,
    output logic [31:0] data_write,
    output logic        edge_filter_done,
    output logic [16:0] kept_count
);

    localparam logic [9:0]  ROW_FIRST = 10'(FIRST_ROW);
    localparam logic [9:0]  ROW_LAST  = 10'(LAST_ROW);
    localparam logic [9:0]  COL_LAST  = 10'(IMG_WIDTH - 1);
    localparam logic [17:0] W18       = 18'(IMG_WIDTH);
    localparam logic [17:0] SRC18     = 18'(SRC_BASE);
    localparam logic [17:0] DST18     = 18'(DST_BASE);

    function automatic logic [17:0] pix_addr(input logic [17:0] base,
                                             input logic [9:0]  r,
                                             input logic [9:0]  c);
        return base + 18'(r) * W18 + 18'(c);
    endfunction

    state_t     state;
    logic [9:0] row;
    logic [9:0] col;
    logic [3:0] step;
    logic [3:0] nxt_j;
    logic [3:0] cap_j;
    win_t       win_p1;
    win_t       win_nxt;
    logic       keep;
    logic       pause_p1;
    logic       rd_hold_p1;
    logic       rd_bit;
    logic       unused_rd;

    assign unused_rd = ^data_read[31:1];
    assign nxt_j     = step + 4'd1;

    // While paused the memory keeps re-reading the held address, so the word that was
    // in flight when the pause began is parked here and consumed on the first resumed cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pause_p1 <= 1'b0;
        else          pause_p1 <= pause;
    end

    // Park the in-flight read bit on the first paused cycle.
    always_ff @(posedge clk) begin
        if (pause && !pause_p1) rd_hold_p1 <= data_read[0];
    end

    assign rd_bit = pause_p1 ? rd_hold_p1 : data_read[0];

    // Next window: insert the returning read during PRIME/READ, shift left after each WRITE.
    always_comb begin
        win_nxt = win_p1;
        cap_j   = step - 4'd1;
        case (state)
            PRIME:   if (step != 4'd0) win_nxt[prime_dr(cap_j)][prime_dc(cap_j)] = rd_bit;
            READ:    if (step != 4'd0) win_nxt[2'(cap_j)][2] = rd_bit;
            WRITE:   for (int r = 0; r < 3; r++) win_nxt[r] = {1'b0, win_p1[r][2:1]};
            default: ;
        endcase
    end

    // Window bits are pure data, fully reloaded by PRIME before they are first evaluated.
    always_ff @(posedge clk) begin
        if (!pause) win_p1 <= win_nxt;
    end

    edge_window_eval u_eval (
        .win            (win_nxt),
        .min_neighbours (min_neighbours),
        .keep           (keep)
    );

    // Run sequencer: row/col walk, read issue, output writes and the sequencer handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            row              <= '0;
            col              <= '0;
            step             <= '0;
            wren             <= 1'b0;
            address          <= '0;
            data_write       <= '0;
            edge_filter_done <= 1'b0;
            kept_count       <= '0;
        end else if (!pause) begin
            if (state != IDLE && !enable_edge_filter) begin
                state            <= IDLE;
                wren             <= 1'b0;
                address          <= '0;
                data_write       <= '0;
                edge_filter_done <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable_edge_filter && !edge_filter_done) begin
                            row        <= ROW_FIRST;
                            col        <= '0;
                            kept_count <= '0;
                            state      <= BORDER;
                            wren       <= 1'b1;
                            address    <= pix_addr(DST18, ROW_FIRST, 10'd0);
                            data_write <= '0;
                        end
                    end
                    BORDER: begin
                        if (col == 10'd0) begin
                            col     <= 10'd1;
                            step    <= '0;
                            state   <= PRIME;
                            wren    <= 1'b0;
                            address <= pix_addr(SRC18, row - 10'd1, 10'd0);
                        end else if (row == ROW_LAST) begin
                            state            <= DONE;
                            wren             <= 1'b0;
                            edge_filter_done <= 1'b1;
                        end else begin
                            row        <= row + 10'd1;
                            col        <= '0;
                            address    <= pix_addr(DST18, row + 10'd1, 10'd0);
                            data_write <= '0;
                        end
                    end
                    PRIME: begin
                        step <= nxt_j;
                        if (step < 4'd8) begin
                            address <= pix_addr(SRC18, row - 10'd1 + 10'(prime_dr(nxt_j)),
                                                col - 10'd1 + 10'(prime_dc(nxt_j)));
                        end
                        if (step == 4'd9) begin
                            state      <= WRITE;
                            wren       <= 1'b1;
                            address    <= pix_addr(DST18, row, col);
                            data_write <= {31'd0, keep};
                            kept_count <= kept_count + 17'(keep);
                        end
                    end
                    READ: begin
                        step <= nxt_j;
                        if (step < 4'd2) begin
                            address <= pix_addr(SRC18, row + 10'(nxt_j) - 10'd1, col + 10'd1);
                        end
                        if (step == 4'd3) begin
                            state      <= WRITE;
                            wren       <= 1'b1;
                            address    <= pix_addr(DST18, row, col);
                            data_write <= {31'd0, keep};
                            kept_count <= kept_count + 17'(keep);
                        end
                    end
                    WRITE: begin
                        col <= col + 10'd1;
                        if (col + 10'd1 == COL_LAST) begin
                            state      <= BORDER;
                            address    <= pix_addr(DST18, row, COL_LAST);
                            data_write <= '0;
                        end else begin
                            state   <= READ;
                            step    <= '0;
                            wren    <= 1'b0;
                            address <= pix_addr(SRC18, row - 10'd1, col + 10'd2);
                        end
                    end
                    DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_edge_noise_filter.sv
// Bench for edge_noise_filter on a reduced image, checked against a neighbour-count model.
module tb_edge_noise_filter;

    localparam int W       = 16;
    localparam int FR      = 2;
    localparam int LR      = 9;
    localparam int SB      = 32;
    localparam int DB      = 4096;
    localparam int NR      = LR + 2;
    localparam int NPIX    = NR * W;
    localparam int ROW_CYC = 2 + 11 + (W - 3) * 5;
    localparam int RUN_CYC = (LR - FR + 1) * ROW_CYC;
    localparam int NOUT    = (LR - FR + 1) * W;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        pause;
    logic        enable_edge_filter;
    logic [3:0]  min_neighbours;
    logic [31:0] data_read;
    logic        wren;
    logic [17:0] address;
    logic [31:0] data_write;
    logic        edge_filter_done;
    logic [16:0] kept_count;

    int checks   = 0;
    int failures = 0;

    bit          img     [NR][W];
    logic [31:0] src_mem [NPIX];
    logic [31:0] dst_mem [NPIX];
    bit          clr_dst = 1'b0;
    int          wr_count = 0;
    int          bad_wr   = 0;

    edge_noise_filter #(
        .IMG_WIDTH (W),
        .SRC_BASE  (SB),
        .DST_BASE  (DB),
        .FIRST_ROW (FR),
        .LAST_ROW  (LR)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .pause              (pause),
        .enable_edge_filter (enable_edge_filter),
        .min_neighbours     (min_neighbours),
        .data_read          (data_read),
        .wren               (wren),
        .address            (address),
        .data_write         (data_write),
        .edge_filter_done   (edge_filter_done),
        .kept_count         (kept_count)
    );

    always #5 clk = ~clk;

    // Single-port memory: one-cycle registered read, write on the strobe.
    always @(posedge clk) begin
        int a;
        if (clr_dst) begin
            foreach (dst_mem[i]) dst_mem[i] <= 32'hDEAD_BEEF;
            wr_count <= 0;
            bad_wr   <= 0;
        end else if (wren) begin
            a = int'(address) - DB;
            if (a >= 0 && a < NPIX) dst_mem[a] <= data_write;
            else bad_wr <= bad_wr + 1;
            if (!pause) wr_count <= wr_count + 1;
        end
        a = int'(address) - SB;
        data_read <= (a >= 0 && a < NPIX) ? src_mem[a] : 32'h5A5A_5A5A;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: an edge pixel survives when at least mn of its 8 neighbours are edges.
    function automatic bit ref_pix(int r, int c, int mn);
        int n = 0;
        if (c == 0 || c == W - 1) return 1'b0;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (dr != 0 || dc != 0) n += int'(img[r + dr][c + dc]);
        return img[r][c] && (n >= mn);
    endfunction

    task automatic clear_img();
        foreach (img[r, c]) img[r][c] = 1'b0;
    endtask

    task automatic fill_rand(input int pct);
        foreach (img[r, c]) img[r][c] = ($urandom_range(0, 99) < pct);
    endtask

    // Upper bits are random so that only bit 0 may influence the result.
    task automatic load_src();
        logic [31:0] w;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < W; c++) begin
                w = $urandom();
                w[0] = img[r][c];
                src_mem[r * W + c] = w;
            end
    endtask

    task automatic start_run(input int mn);
        load_src();
        min_neighbours = 4'(mn);
        clr_dst = 1'b1;
        tick();
        clr_dst = 1'b0;
        enable_edge_filter = 1'b1;
    endtask

    task automatic run(input string tag, input int mn, input bit do_pause);
        int cyc = 0;
        int paused = 0;
        int budget;
        int kept_ref = 0;
        bit seen_done = 1'b0;
        logic [31:0] e;
        start_run(mn);
        budget = do_pause ? 50 : 0;
        while (!seen_done && cyc < 3 * RUN_CYC) begin
            if (budget > 0 && $urandom_range(0, 3) == 0) begin
                pause = 1'b1;
                budget--;
                paused++;
            end else begin
                pause = 1'b0;
            end
            tick();
            cyc++;
            seen_done = edge_filter_done;
        end
        pause = 1'b0;
        check({tag, " done"}, 32'(seen_done), 32'd1);
        check({tag, " cycles"}, cyc, RUN_CYC + 1 + paused);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < W; c++) begin
                if (r >= FR && r <= LR) begin
                    e = {31'd0, ref_pix(r, c, mn)};
                    kept_ref += int'(e[0]);
                end else begin
                    e = 32'hDEAD_BEEF;
                end
                check($sformatf("%s px r%0d c%0d", tag, r, c), dst_mem[r * W + c], e);
            end
        check({tag, " kept"}, 32'(kept_count), kept_ref);
        check({tag, " writes"}, wr_count, NOUT);
        check({tag, " stray writes"}, bad_wr, 0);
        enable_edge_filter = 1'b0;
        tick();
        check({tag, " done clear"}, 32'(edge_filter_done), 32'd0);
        check({tag, " wren clear"}, 32'(wren), 32'd0);
        check({tag, " addr clear"}, 32'(address), 32'd0);
        check({tag, " data clear"}, data_write, 32'd0);
    endtask

    initial begin
        int n;
        int c;
        int wc;
        bit found;

        reset_n = 1'b0;
        pause = 1'b0;
        enable_edge_filter = 1'b0;
        min_neighbours = 4'd0;
        repeat (3) tick();
        check("reset wren", 32'(wren), 32'd0);
        check("reset addr", 32'(address), 32'd0);
        check("reset data", data_write, 32'd0);
        check("reset done", 32'(edge_filter_done), 32'd0);
        check("reset kept", 32'(kept_count), 32'd0);
        reset_n = 1'b1;
        tick();

        clear_img();
        run("zero", 2, 1'b0);
        check("zero kept const", 32'(kept_count), 32'd0);

        clear_img();
        img[5][7] = 1'b1;
        run("single", 1, 1'b0);
        check("single px const", dst_mem[5 * W + 7], 32'd0);
        check("single kept const", 32'(kept_count), 32'd0);

        clear_img();
        for (int r = 4; r <= 6; r++)
            for (int cc = 6; cc <= 8; cc++) img[r][cc] = 1'b1;
        run("block", 2, 1'b0);
        check("block kept const", 32'(kept_count), 32'd9);

        clear_img();
        for (int cc = 3; cc <= 10; cc++) img[6][cc] = 1'b1;
        run("line min2", 2, 1'b0);
        check("line min2 kept const", 32'(kept_count), 32'd6);
        check("line min2 end", dst_mem[6 * W + 3], 32'd0);
        run("line min1", 1, 1'b0);
        check("line min1 kept const", 32'(kept_count), 32'd8);
        run("line pause", 2, 1'b1);
        check("line pause kept const", 32'(kept_count), 32'd6);

        begin
            int mins [5] = '{0, 4, 8, 9, 15};
            foreach (mins[i]) begin
                fill_rand($urandom_range(30, 65));
                run($sformatf("rand min%0d", mins[i]), mins[i], i[0]);
            end
        end

        fill_rand(50);
        start_run(3);
        repeat (200) tick();
        enable_edge_filter = 1'b0;
        tick();
        check("abort wren", 32'(wren), 32'd0);
        check("abort addr", 32'(address), 32'd0);
        check("abort data", data_write, 32'd0);
        check("abort done", 32'(edge_filter_done), 32'd0);
        check("abort partial kept in mem", dst_mem[FR * W], 32'd0);
        run("restart", 3, 1'b0);

        fill_rand(50);
        start_run(2);
        found = 1'b0;
        n = 0;
        while (!found && n < 2 * RUN_CYC) begin
            tick();
            n++;
            c = (int'(address) - DB) % W;
            if (n > 300 && wren && int'(address) >= DB && c != 0 && c != W - 1) found = 1'b1;
        end
        check("rst found write", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst wren", 32'(wren), 32'd0);
        check("rst addr", 32'(address), 32'd0);
        check("rst data", data_write, 32'd0);
        check("rst done", 32'(edge_filter_done), 32'd0);
        check("rst kept", 32'(kept_count), 32'd0);
        wc = wr_count;
        enable_edge_filter = 1'b0;
        repeat (3) tick();
        check("rst no later write", wr_count, wc);
        reset_n = 1'b1;
        tick();
        run("post reset", 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
